// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the register-file write-back controller:
// queue depth default, queued-write entry type and the zero register.
package regfile_wb_pkg;

   localparam int unsigned WB_DEPTH = 4;
   localparam logic [4:0]  REG_ZERO = 5'd0;

   typedef struct packed {
      logic [4:0]  wr;
      logic [31:0] d;
   } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue.sv
// Circular write-back buffer: up to two enqueues (A then B) and one dequeue per
// cycle, exposing every slot with its valid bit for the bypass search.
module regfile_wb_queue
   import regfile_wb_pkg::*;
#(
   parameter  int unsigned DEPTH = WB_DEPTH,
   localparam int unsigned PW    = $clog2(DEPTH),
   localparam int unsigned CW    = PW + 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             enq_a,
   input  wb_entry_t        ent_a,
   input  logic             enq_b,
   input  wb_entry_t        ent_b,
   input  logic             deq,
   output wb_entry_t        head,
   output logic [CW-1:0]    count,
   output logic [PW-1:0]    rd_ptr,
   output wb_entry_t        slot [DEPTH],
   output logic [DEPTH-1:0] slot_vld
);

   wb_entry_t        mem_q [DEPTH];
   wb_entry_t        mem_d [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]    b_ptr;

   always_comb begin
      mem_d  = mem_q;
      vld_d  = vld_q;
      rptr_d = rptr_q;
      // B lands behind A when both are enqueued in the same cycle
      b_ptr  = wptr_q + PW'(enq_a);
      if (deq) begin
         vld_d[rptr_q] = 1'b0;
         rptr_d        = rptr_q + PW'(1);
      end
      if (enq_a) begin
         mem_d[wptr_q] = ent_a;
         vld_d[wptr_q] = 1'b1;
      end
      if (enq_b) begin
         mem_d[b_ptr] = ent_b;
         vld_d[b_ptr] = 1'b1;
      end
      wptr_d = wptr_q + PW'(enq_a) + PW'(enq_b);
      cnt_d  = cnt_q + CW'(enq_a) + CW'(enq_b) - CW'(deq);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         vld_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         vld_q  <= vld_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign head     = mem_q[rptr_q];
   assign count    = cnt_q;
   assign rd_ptr   = rptr_q;
   assign slot     = mem_q;
   assign slot_vld = vld_q;

endmodule

// File: rtl/regfile_wb.sv
// Write-back controller owning the register-file write port: queues ALU and
// load/mul results, retires one per cycle and offers bypass to both readers.
module regfile_wb
   import regfile_wb_pkg::*;
#(
   parameter  int unsigned DEPTH = WB_DEPTH,
   localparam int unsigned PW    = $clog2(DEPTH),
   localparam int unsigned CW    = PW + 1
) (
   input  logic          Clk,
   input  logic          Clr,
   input  logic          ValidA,
   input  logic [4:0]    WrA,
   input  logic [31:0]   DA,
   output logic          ReadyA,
   input  logic          ValidB,
   input  logic [4:0]    WrB,
   input  logic [31:0]   DB,
   output logic          ReadyB,
   output logic          We,
   output logic [4:0]    Wr,
   output logic [31:0]   D,
   input  logic [4:0]    Ra,
   input  logic [4:0]    Rb,
   output logic          HitA,
   output logic          HitB,
   output logic [31:0]   QfA,
   output logic [31:0]   QfB,
   output logic [CW-1:0] Count
);

   logic [CW-1:0]    free;
   logic             enq_a, enq_b, deq;
   wb_entry_t        head;
   wb_entry_t        slot [DEPTH];
   logic [DEPTH-1:0] slot_vld;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    idx;

   always_comb begin
      // no credit for the head retiring this cycle
      free   = CW'(DEPTH) - Count;
      ReadyA = (free >= CW'(1));
      ReadyB = (free >= CW'(2));
      enq_a  = ValidA && ReadyA && (WrA != REG_ZERO);
      enq_b  = ValidB && ReadyB && (WrB != REG_ZERO);
      deq    = (Count != '0);
      We     = deq;
      Wr     = deq ? head.wr : REG_ZERO;
      D      = deq ? head.d  : '0;
   end

   regfile_wb_queue #(.DEPTH(DEPTH)) u_queue (
      .clk      (Clk),
      .clr      (Clr),
      .enq_a    (enq_a),
      .ent_a    ('{wr: WrA, d: DA}),
      .enq_b    (enq_b),
      .ent_b    ('{wr: WrB, d: DB}),
      .deq      (deq),
      .head     (head),
      .count    (Count),
      .rd_ptr   (rd_ptr),
      .slot     (slot),
      .slot_vld (slot_vld)
   );

   // Walk oldest to youngest from the read pointer; later matches override.
   always_comb begin
      HitA = 1'b0;
      HitB = 1'b0;
      QfA  = '0;
      QfB  = '0;
      idx  = '0;
      for (int unsigned p = 0; p < DEPTH; p++) begin
         idx = rd_ptr + PW'(p);
         if (slot_vld[idx] && (Ra != REG_ZERO) && (slot[idx].wr == Ra)) begin
            HitA = 1'b1;
            QfA  = slot[idx].d;
         end
         if (slot_vld[idx] && (Rb != REG_ZERO) && (slot[idx].wr == Rb)) begin
            HitB = 1'b1;
            QfB  = slot[idx].d;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_regfile_wb;
   import regfile_wb_pkg::*;

   localparam int unsigned DEPTH = WB_DEPTH;

   logic        Clk = 1'b0;
   logic        Clr;
   logic        ValidA, ValidB;
   logic [4:0]  WrA, WrB, Ra, Rb;
   logic [31:0] DA, DB;
   logic        ReadyA, ReadyB, We, HitA, HitB;
   logic [4:0]  Wr;
   logic [31:0] D, QfA, QfB;
   logic [2:0]  Count;

   regfile_wb #(.DEPTH(DEPTH)) dut (
      .Clk(Clk), .Clr(Clr),
      .ValidA(ValidA), .WrA(WrA), .DA(DA), .ReadyA(ReadyA),
      .ValidB(ValidB), .WrB(WrB), .DB(DB), .ReadyB(ReadyB),
      .We(We), .Wr(Wr), .D(D),
      .Ra(Ra), .Rb(Rb),
      .HitA(HitA), .HitB(HitB), .QfA(QfA), .QfB(QfB),
      .Count(Count)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [4:0]  wr;
      logic [31:0] d;
   } ref_t;

   ref_t model[$];
   int   errors = 0;
   int   checks = 0;
   logic acc_a, acc_b;
   int   dut_peak, model_peak;

   logic        pa_v, pb_v;
   logic [4:0]  pa_wr, pb_wr;
   logic [31:0] pa_d, pb_d;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, compare all outputs with the model, then advance
   // the model by the queue rules (retire head, then append A, then B).
   task automatic cycle(input logic clr,
                        input logic va, input logic [4:0] wa, input logic [31:0] da,
                        input logic vb, input logic [4:0] wb, input logic [31:0] db,
                        input logic [4:0] ra, input logic [4:0] rb);
      int          n;
      logic        h_a, h_b;
      logic [31:0] q_a, q_b;
      Clr = clr; ValidA = va; WrA = wa; DA = da;
      ValidB = vb; WrB = wb; DB = db; Ra = ra; Rb = rb;
      #1;
      n = model.size();
      h_a = 1'b0; h_b = 1'b0; q_a = '0; q_b = '0;
      for (int i = 0; i < n; i++) begin
         if (ra != 5'd0 && model[i].wr == ra) begin h_a = 1'b1; q_a = model[i].d; end
         if (rb != 5'd0 && model[i].wr == rb) begin h_b = 1'b1; q_b = model[i].d; end
      end
      chk("ready_a", ReadyA, n < DEPTH);
      chk("ready_b", ReadyB, n + 2 <= DEPTH);
      chk("count",   Count,  n);
      chk("we",      We,     n != 0);
      chk("wr",      Wr,     (n != 0) ? model[0].wr : 5'd0);
      chk("d",       D,      (n != 0) ? model[0].d  : 32'd0);
      chk("hit_a",   HitA,   h_a);
      chk("qf_a",    QfA,    q_a);
      chk("hit_b",   HitB,   h_b);
      chk("qf_b",    QfB,    q_b);
      if (int'(Count) > dut_peak) dut_peak = int'(Count);
      if (n > model_peak) model_peak = n;
      acc_a = !clr && va && (n < DEPTH);
      acc_b = !clr && vb && (n + 2 <= DEPTH);
      @(posedge Clk);
      if (clr) begin
         model.delete();
      end else begin
         if (n != 0) void'(model.pop_front());
         if (acc_a && wa != 5'd0) model.push_back('{wr: wa, d: da});
         if (acc_b && wb != 5'd0) model.push_back('{wr: wb, d: db});
      end
      @(negedge Clk);
   endtask

   task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra, rb);
   endtask

   task automatic refresh(input logic force_valid);
      if (!pa_v) begin
         pa_v  = force_valid || ($urandom_range(0, 3) != 0);
         pa_wr = 5'($urandom_range(0, 7));
         pa_d  = $urandom;
      end
      if (!pb_v) begin
         pb_v  = force_valid || ($urandom_range(0, 3) != 0);
         pb_wr = 5'($urandom_range(0, 7));
         pb_d  = $urandom;
      end
   endtask

   task automatic traffic(input logic force_valid, input logic rst);
      refresh(force_valid);
      cycle(rst, pa_v, pa_wr, pa_d, pb_v, pb_wr, pb_d,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if (acc_a) pa_v = 1'b0;
      if (acc_b) pb_v = 1'b0;
   endtask

   initial begin
      Clr = 1'b1; ValidA = 1'b0; ValidB = 1'b0;
      WrA = '0; WrB = '0; DA = '0; DB = '0; Ra = '0; Rb = '0;
      pa_v = 1'b0; pb_v = 1'b0; pa_wr = '0; pb_wr = '0; pa_d = '0; pb_d = '0;
      dut_peak = 0; model_peak = 0;
      @(posedge Clk);
      @(negedge Clk);
      Clr = 1'b0;
      #1;
      chk("rst_count",  Count,  0);
      chk("rst_we",     We,     0);
      chk("rst_wr",     Wr,     0);
      chk("rst_d",      D,      0);
      chk("rst_hit",    {HitA, HitB}, 0);
      chk("rst_qf",     QfA | QfB, 0);
      chk("rst_ready",  {ReadyA, ReadyB}, 2'b11);

      // single write
      cycle(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      chk("single_we", We, 1);
      chk("single_wr", Wr, 5);
      chk("single_d",  D,  32'h1234_5678);
      idle(5'd0, 5'd0);
      chk("single_we_after",    We,    0);
      chk("single_count_after", Count, 0);

      // dual accept to the same register
      cycle(1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, 5'd3, 5'd0);
      chk("dual_count", Count, 2);
      chk("dual_hit",   HitA,  1);
      chk("dual_qf",    QfA,   32'hB);
      chk("dual_wr0",   Wr,    3);
      chk("dual_d0",    D,     32'hA);
      idle(5'd3, 5'd0);
      chk("dual_d1",    D,     32'hB);
      chk("dual_qf1",   QfA,   32'hB);
      idle(5'd0, 5'd0);

      // r0 destination is accepted but never queued
      cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      chk("r0_count", Count, 0);
      chk("r0_we",    We,    0);

      // bypass hit / miss
      cycle(1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 5'd7, 5'd8);
      chk("byp_hit_a", HitA, 1);
      chk("byp_qf_a",  QfA,  32'h77);
      chk("byp_hit_b", HitB, 0);
      chk("byp_qf_b",  QfB,  0);
      idle(5'd7, 5'd8);
      chk("byp_hit_a_gone", HitA, 0);

      // back-pressure: both producers always valid. Because the head always
      // retires, occupancy settles at DEPTH-1 with only A accepted per cycle.
      dut_peak = 0; model_peak = 0;
      for (int c = 0; c < 12; c++) begin
         pa_v = 1'b0; pb_v = 1'b0;
         pa_wr = 5'($urandom_range(1, 31)); pb_wr = 5'($urandom_range(1, 31));
         pa_d = $urandom; pb_d = $urandom;
         cycle(1'b0, 1'b1, pa_wr, pa_d, 1'b1, pb_wr, pb_d, 5'd0, 5'd0);
      end
      chk("fill_peak", dut_peak, model_peak);
      for (int c = 0; c < 6; c++) idle(5'd0, 5'd0);

      // reset with three entries queued
      cycle(1'b0, 1'b1, 5'd9,  32'h9,  1'b1, 5'd10, 32'h10, 5'd0, 5'd0);
      cycle(1'b0, 1'b1, 5'd11, 32'h11, 1'b1, 5'd12, 32'h12, 5'd0, 5'd0);
      chk("pre_rst_count", Count, 3);
      cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      chk("mid_rst_count", Count, 0);
      chk("mid_rst_we",    We,    0);
      idle(5'd0, 5'd0);

      // random traffic with held offers and occasional reset
      pa_v = 1'b0; pb_v = 1'b0;
      for (int c = 0; c < 400; c++) begin
         traffic(1'b0, $urandom_range(0, 49) == 0);
      end
      for (int c = 0; c < 6; c++) idle(5'd0, 5'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
